// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch stage with a DEPTH-entry queue between
// fetch and decode. Each cycle the word at the fetch PC is captured at the
// tail; decode consumes from the head. A redirect flushes the queue and
// restarts fetch at the (word-aligned) target.
// Optional feature: define IF_FETCH_PERF_CNT_EN to add perf_stall_cycles,
// a saturating count of cycles where fetch was blocked by a full queue.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  input  logic                    D_stall,
  input  logic [31:0]             i_inst_rdata,
  output logic [31:0]             i_inst_addr,
  output logic [31:0]             instr_D,
  output logic [31:0]             pc_D,
  output logic                    valid_D,
  output logic [$clog2(DEPTH):0]  count,
`ifdef IF_FETCH_PERF_CNT_EN
  output logic [31:0]             perf_stall_cycles,
`endif
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc_q, pc_d;
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_pc_q    [DEPTH];
  logic [31:0]   mem_instr_q [DEPTH];
  logic          pop, push;
  logic [31:0]   redirect_tgt;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

  assign i_inst_addr = pc_q;
  assign count       = count_q;
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign valid_D     = ~empty;
  assign instr_D     = valid_D ? mem_instr_q[head_q] : 32'h0;
  assign pc_D        = valid_D ? mem_pc_q[head_q]    : 32'h0;

  // Handshake: a full queue may still accept when the head leaves on the same edge.
  assign pop  = valid_D & ~D_stall & ~redirect;
  assign push = (~full | pop) & ~redirect & reset;

  // Next-state for fetch PC and queue pointers; redirect overrides everything.
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      pc_d    = redirect_tgt;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + 32'd4;
        tail_d = tail_q + AW'(1);
      end
      if (pop) begin
        head_d = head_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= PC_RESET;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage; entries outside head..tail are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[tail_q]    <= pc_q;
      mem_instr_q[tail_q] <= i_inst_rdata;
    end
  end

`ifdef IF_FETCH_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  assign perf_stall_cycles = perf_q;

  // Count fetch-blocked cycles, holding at all-ones instead of wrapping.
  always_comb begin
    perf_d = perf_q;
    if (full && !pop && !redirect && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Stall counter register, cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_q <= 32'h0;
    end else begin
      perf_q <= perf_d;
    end
  end
`endif

endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, meaning: instruction-queue entries; power of two, 2..16.
REQ-002 Parameter PC_RESET, default 32'h0000_3000, meaning: first fetch address after reset.
REQ-003 Port clk  input  1  meaning: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  meaning: asynchronous, active-low reset (asserted when 0).
REQ-005 Port redirect  input  1  meaning: branch/jump redirect request from decode.
REQ-006 Port redirect_pc  input  32  meaning: redirect target address.
REQ-007 Port D_stall  input  1  meaning: decode not accepting; head entry held.
REQ-008 Port i_inst_rdata  input  32  meaning: instruction word for i_inst_addr, same cycle (combinational memory).
REQ-009 Port i_inst_addr  output  32  meaning: current fetch PC.
REQ-010 Port instr_D  output  32  meaning: head-entry instruction.
REQ-011 Port pc_D  output  32  meaning: head-entry PC.
REQ-012 Port valid_D  output  1  meaning: head entry present.
REQ-013 Port count  output  $clog2(DEPTH)+1  meaning: occupied entries.
REQ-014 Port full / empty  output  1 each  meaning: count==DEPTH / count==0.

Function
REQ-015 pop = valid_D & ~D_stall & ~redirect; push = (~full | pop) & ~redirect.
REQ-016 On push: entry {pc, i_inst_rdata} written at tail; tail pointer +1 modulo DEPTH; fetch PC +4, wrapping 32'hFFFF_FFFC -> 32'h0.
REQ-017 On pop: head pointer +1 modulo DEPTH.
REQ-018 Push and pop in same cycle: count unchanged; legal when full (entry freed and refilled same edge).
REQ-019 Full and no pop: no push; fetch PC held; i_inst_addr stable.
REQ-020 Latency: instruction fetched at edge N is visible on instr_D/pc_D/valid_D after edge N when queue was empty (1 cycle, same as single IF/ID register).
REQ-021 instr_D, pc_D, valid_D driven combinationally from head entry; when empty, instr_D=0 (nop), pc_D=0, valid_D=0.
REQ-022 Redirect has priority over push, pop and stall: at the edge, queue emptied (count=0, head=tail=0), fetch PC <= {redirect_pc[31:2],2'b00}; no entry written that cycle.
REQ-023 First instruction from redirect target appears on instr_D two edges after the redirect edge.
REQ-024 count changes by at most 1 per cycle except on redirect (to 0); count never exceeds DEPTH.
REQ-025 Queue contents beyond head..tail are don't-care; outputs never expose them.

Reset
REQ-026 reset=0 asynchronously forces: fetch PC=PC_RESET, head=tail=0, count=0, valid_D=0, instr_D=0, pc_D=0, empty=1, full=0.
REQ-027 Reset mid-operation discards all queued entries and any pending redirect; first fetch after release is PC_RESET.
REQ-028 Reset deassertion taken synchronously by the design's flops on the next clk edge; no push occurs while reset=0.

Configuration
REQ-029 Macro IF_FETCH_PERF_CNT_EN defined: extra output perf_stall_cycles (32 bits) counts cycles with full & ~pop & ~redirect, saturating at 32'hFFFF_FFFF, cleared by reset.
REQ-030 Macro undefined: port perf_stall_cycles and counter absent; all other behaviour identical.

Verification
REQ-031 Reset release, D_stall=0, memory word = address: pc_D/instr_D = 0x3000,0x3004,0x3008 on consecutive cycles after first edge; count stays 1.
REQ-032 DEPTH=4, D_stall=1 from reset: count 1,2,3,4 then full=1; i_inst_addr holds 0x3010; head stays pc_D=0x3000.
REQ-033 Full queue, D_stall drops for one cycle: pc_D advances to 0x3004, 0x3010 pushed same edge, count stays 4, i_inst_addr -> 0x3014.
REQ-034 Full queue, redirect=1 with redirect_pc=0x0000_4002 and D_stall=0: next cycle count=0, valid_D=0, i_inst_addr=0x4000; following cycle pc_D=0x4000.
REQ-035 Fetch PC forced to 0xFFFF_FFFC via redirect: next pushes carry PCs 0xFFFF_FFFC then 0x0000_0000.
REQ-036 reset pulsed low mid-cycle with count=3: outputs cleared immediately without clk edge; with IF_FETCH_PERF_CNT_EN, perf_stall_cycles reads 0.
